// File: rtl/song_pkg.sv
// Shared state encoding and default widths for the song sequencer.
// Looping behaviour is selected in the top with macro SONG_LOOP_EN.
package song_pkg;

    localparam int DEF_NOTE_W = 6;
    localparam int DEF_DUR_W  = 6;
    localparam int DEF_IDX_W  = 5;
    localparam int DEF_SONG_W = 2;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        LOAD      = 3'd2,
        WAIT_NOTE = 3'd3,
        DONE      = 3'd4
    } state_t;

endpackage

// File: rtl/song_rom.sv
// Synchronous song ROM: address {song, index}, data {note, duration}.
// Duration 0 marks the end of a song.
module song_rom
    import song_pkg::*;
#(
    parameter int NOTE_W = DEF_NOTE_W,
    parameter int DUR_W  = DEF_DUR_W,
    parameter int IDX_W  = DEF_IDX_W,
    parameter int SONG_W = DEF_SONG_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [SONG_W+IDX_W-1:0]   addr,
    output logic [NOTE_W+DUR_W-1:0]   data
);

    localparam int ADDR_W = SONG_W + IDX_W;

    function automatic logic [NOTE_W+DUR_W-1:0] entry(
        input logic [SONG_W-1:0] s,
        input logic [IDX_W-1:0]  i
    );
        int n;
        int d;
        int ii;
        ii = int'(i);
        n  = 0;
        d  = 0;
        case (int'(s))
            0: if (ii < 4) begin
                n = 12 + 2 * ii;
                d = 6 + ii;
            end
            1: if (ii < 2) begin
                n = 20 + ii;
                d = 3;
            end
            2: if (ii < 8) begin
                n = 30 + ii;
                d = 5;
            end
            default: begin
                n = ii + 1;
                d = (ii % 8) + 1;
            end
        endcase
        return {NOTE_W'(n), DUR_W'(d)};
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data <= '0;
        end else begin
            data <= entry(addr[ADDR_W-1 -: SONG_W], addr[IDX_W-1:0]);
        end
    end

endmodule

// File: rtl/song_sequencer.sv
// Steps through a ROM song and hands notes to the note player.
// Define SONG_LOOP_EN to restart the song instead of stopping at its end.
module song_sequencer
    import song_pkg::*;
#(
    parameter int NOTE_W = DEF_NOTE_W,
    parameter int DUR_W  = DEF_DUR_W,
    parameter int IDX_W  = DEF_IDX_W,
    parameter int SONG_W = DEF_SONG_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              play,
    input  logic [SONG_W-1:0] song,
    input  logic              note_done,
    output logic              play_enable,
    output logic [NOTE_W-1:0] note_to_load,
    output logic [DUR_W-1:0]  duration_to_load,
    output logic              load_new_note,
    output logic              song_done
);

    localparam logic [IDX_W-1:0] LAST_IDX = '1;

    state_t state;
    state_t state_next;

    logic [IDX_W-1:0]        index;
    logic [IDX_W-1:0]        index_next;
    logic [SONG_W-1:0]       last_song;
    logic                    song_changed;
    logic                    load_fire;
    logic [NOTE_W+DUR_W-1:0] rom_data;
    logic [NOTE_W-1:0]       rom_note;
    logic [DUR_W-1:0]        rom_dur;

    assign {rom_note, rom_dur} = rom_data;
    assign song_changed = (song != last_song);

    song_rom #(
        .NOTE_W (NOTE_W),
        .DUR_W  (DUR_W),
        .IDX_W  (IDX_W),
        .SONG_W (SONG_W)
    ) u_rom (
        .clk   (clk),
        .reset (reset),
        .addr  ({song, index}),
        .data  (rom_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        index_next = index;
        load_fire  = 1'b0;
        unique case (state)
            IDLE: begin
                index_next = '0;
                if (play) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                if (song_changed) begin
                    index_next = '0;
                    state_next = FETCH;
                end else begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                if (song_changed) begin
                    index_next = '0;
                    state_next = FETCH;
                end else if (rom_dur == '0) begin
                    index_next = '0;
                    state_next = DONE;
                end else begin
                    load_fire  = 1'b1;
                    state_next = WAIT_NOTE;
                end
            end
            WAIT_NOTE: begin
                if (song_changed) begin
                    index_next = '0;
                    state_next = FETCH;
                end else if (note_done && play) begin
                    // the last slot ends the song rather than wrapping
                    if (index == LAST_IDX) begin
                        index_next = '0;
                        state_next = DONE;
                    end else begin
                        index_next = index + IDX_W'(1);
                        state_next = FETCH;
                    end
                end
            end
            DONE: begin
                index_next = '0;
`ifdef SONG_LOOP_EN
                state_next = FETCH;
`else
                if (!play || song_changed) begin
                    state_next = IDLE;
                end
`endif
            end
            default: begin
                index_next = '0;
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        play_enable = (state == WAIT_NOTE) && play;
        song_done   = (state == DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            index            <= '0;
            last_song        <= '0;
            note_to_load     <= '0;
            duration_to_load <= '0;
            load_new_note    <= 1'b0;
        end else begin
            index         <= index_next;
            last_song     <= song;
            load_new_note <= load_fire;
            if (load_fire) begin
                note_to_load     <= rom_note;
                duration_to_load <= rom_dur;
            end
        end
    end

endmodule

// File: tb/tb_song_sequencer.sv
// Bench for song_sequencer: directed steps with random gaps and pauses,
// checked against a note-level model of the song tables.
module tb_song_sequencer;

    localparam int NW = 6;
    localparam int DW = 6;
    localparam int IW = 5;
    localparam int SW = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          play = 1'b0;
    logic          note_done = 1'b0;
    logic [SW-1:0] song = '0;
    logic          play_enable;
    logic          load_new_note;
    logic          song_done;
    logic [NW-1:0] note_to_load;
    logic [DW-1:0] duration_to_load;

    int checks = 0;
    int errors = 0;
    int note_m[4][32];
    int dur_m[4][32];
    int cur_song;
    int cur_idx;
    int s_k, d_k, n_str, n_done, s_note, s_dur, pe_seen;
    int quiet;

    song_sequencer #(
        .NOTE_W (NW),
        .DUR_W  (DW),
        .IDX_W  (IW),
        .SONG_W (SW)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .play             (play),
        .song             (song),
        .note_done        (note_done),
        .play_enable      (play_enable),
        .note_to_load     (note_to_load),
        .duration_to_load (duration_to_load),
        .load_new_note    (load_new_note),
        .song_done        (song_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Watch n cycles, recording first strobe and first song_done.
    task automatic observe(input int n);
        s_k = 0; d_k = 0; n_str = 0; n_done = 0;
        s_note = -1; s_dur = -1; pe_seen = 0;
        for (int k = 1; k <= n; k++) begin
            tick();
            note_done = 1'b0;
            if (load_new_note === 1'b1) begin
                n_str++;
                if (s_k == 0) begin
                    s_k = k;
                    s_note = int'(note_to_load);
                    s_dur = int'(duration_to_load);
                end
            end
            if (song_done === 1'b1) begin
                n_done++;
                if (d_k == 0) d_k = k;
            end
            if (play_enable === 1'b1) pe_seen++;
        end
    endtask

    function automatic bit is_end(int s, int i);
        if (i == 31) return 1'b1;
        return dur_m[s][i+1] == 0;
    endfunction

    task automatic start_play(input string tag);
        play = 1'b1;
        observe(6);
        chk({tag, "_lat"}, s_k, 3);
        chk({tag, "_note"}, s_note, note_m[cur_song][0]);
        chk({tag, "_dur"}, s_dur, dur_m[cur_song][0]);
        chk({tag, "_pe"}, pe_seen, 4);
        cur_idx = 0;
    endtask

    task automatic finish_note(input string tag);
        bit fin;
        int done_at;
        fin = is_end(cur_song, cur_idx);
        done_at = (cur_idx == 31) ? 1 : 3;
        note_done = 1'b1;
        observe(10);
        if (!fin) begin
            chk({tag, "_lat"}, s_k, 3);
            chk({tag, "_nstr"}, n_str, 1);
            chk({tag, "_note"}, s_note, note_m[cur_song][cur_idx+1]);
            chk({tag, "_dur"}, s_dur, dur_m[cur_song][cur_idx+1]);
            chk({tag, "_nodone"}, n_done, 0);
            cur_idx++;
        end else begin
`ifdef SONG_LOOP_EN
            chk({tag, "_done_at"}, d_k, done_at);
            chk({tag, "_done_pulse"}, n_done, 1);
            chk({tag, "_loop_lat"}, s_k, done_at + 3);
            chk({tag, "_loop_note"}, s_note, note_m[cur_song][0]);
            cur_idx = 0;
`else
            chk({tag, "_done_at"}, d_k, done_at);
            chk({tag, "_no_strobe"}, n_str, 0);
            chk({tag, "_done_lvl"}, 32'(song_done), 1);
`endif
        end
    endtask

    task automatic pause_ignore(input string tag);
        play = 1'b0;
        #1;
        chk({tag, "_pe_off"}, 32'(play_enable), 0);
        note_done = 1'b1;
        observe(4);
        chk({tag, "_no_strobe"}, n_str, 0);
        chk({tag, "_pe_seen"}, pe_seen, 0);
        chk({tag, "_hold"}, 32'(note_to_load), note_m[cur_song][cur_idx]);
        play = 1'b1;
        #1;
        chk({tag, "_pe_on"}, 32'(play_enable), 1);
    endtask

    initial begin
        for (int s = 0; s < 4; s++) begin
            for (int i = 0; i < 32; i++) begin
                note_m[s][i] = 0;
                dur_m[s][i] = 0;
            end
        end
        for (int i = 0; i < 4; i++) begin
            note_m[0][i] = 12 + 2 * i;
            dur_m[0][i] = 6 + i;
        end
        for (int i = 0; i < 2; i++) begin
            note_m[1][i] = 20 + i;
            dur_m[1][i] = 3;
        end
        for (int i = 0; i < 8; i++) begin
            note_m[2][i] = 30 + i;
            dur_m[2][i] = 5;
        end
        for (int i = 0; i < 32; i++) begin
            note_m[3][i] = i + 1;
            dur_m[3][i] = (i % 8) + 1;
        end

        // Reset state, then quiet idle
        repeat (3) tick();
        chk("rst_load", 32'(load_new_note), 0);
        chk("rst_pe", 32'(play_enable), 0);
        chk("rst_done", 32'(song_done), 0);
        chk("rst_note", 32'(note_to_load), 0);
        chk("rst_dur", 32'(duration_to_load), 0);
        reset = 1'b1;
        quiet = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if ({load_new_note, play_enable, song_done} !== 3'b000) quiet++;
            if ({note_to_load, duration_to_load} !== '0) quiet++;
        end
        chk("idle_quiet", quiet, 0);

        // First note of song 0
        cur_song = 0;
        song = 2'd0;
        start_play("first");
        chk("first_note_abs", s_note, 12);
        chk("first_dur_abs", s_dur, 6);

        repeat ($urandom_range(0, 3)) tick();
        finish_note("n1");
        pause_ignore("pause1");
        finish_note("n2");

        // Song change coinciding with note_done
        song = 2'd2;
        note_done = 1'b1;
        observe(6);
        chk("chg_lat", s_k, 3);
        chk("chg_note", s_note, note_m[2][0]);
        chk("chg_dur", s_dur, dur_m[2][0]);
        cur_song = 2;
        cur_idx = 0;

        // Asynchronous reset mid-note, then restart at index 0
        reset = 1'b0;
        #1;
        chk("mid_rst_load", 32'(load_new_note), 0);
        chk("mid_rst_pe", 32'(play_enable), 0);
        chk("mid_rst_note", 32'(note_to_load), 0);
        chk("mid_rst_dur", 32'(duration_to_load), 0);
        tick();
        song = 2'd0;
        cur_song = 0;
        reset = 1'b1;
        observe(6);
        chk("restart_lat", s_k, 3);
        chk("restart_note", s_note, note_m[0][0]);

        // Play song 0 to its end marker
        for (int n = 0; n < 4; n++) begin
            repeat ($urandom_range(0, 2)) tick();
            finish_note($sformatf("s0_n%0d", n + 1));
        end
        play = 1'b0;
        tick();
`ifndef SONG_LOOP_EN
        chk("stop_done_clr", 32'(song_done), 0);
`endif
        chk("stop_pe", 32'(play_enable), 0);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();

        // Full 32-note song exercises the last-index boundary
        song = 2'd3;
        cur_song = 3;
        start_play("s3_start");
        for (int n = 0; n < 32; n++) begin
            repeat ($urandom_range(0, 2)) tick();
            if ($urandom_range(0, 5) == 0) pause_ignore($sformatf("s3_p%0d", n));
            finish_note($sformatf("s3_n%0d", n + 1));
        end

`ifndef SONG_LOOP_EN
        // Song change while parked in DONE with play held high
        song = 2'd1;
        cur_song = 1;
        observe(8);
        chk("done_chg_clr", n_done, 0);
        chk("done_chg_lat", s_k, 4);
        chk("done_chg_note", s_note, note_m[1][0]);
        chk("done_chg_dur", s_dur, dur_m[1][0]);
        cur_idx = 0;
        finish_note("s1_n1");
        finish_note("s1_end");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
